// File: rtl/deadlock_collect_pkg.sv
// Shared types and helpers for the deadlock report collector.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package deadlock_collect_pkg;

    // Collector FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WATCH   = 2'd1,
        REPORT  = 2'd2,
        LATCHED = 2'd3
    } dl_state_t;

    // Upper bound on monitor count handled by the generic index helper.
    localparam int DL_MAX_MON  = 64;
    localparam int DL_MAX_IDX_W = $clog2(DL_MAX_MON);

    // Default confirmation window and the hold-counter width it implies.
    // The counter must be able to hold the value CONFIRM_CYCLES itself.
    localparam int DL_CONFIRM_DFLT = 16;
    localparam int DL_HOLD_W_DFLT  = $clog2(DL_CONFIRM_DFLT + 1);

    function automatic int hold_cnt_w(input int confirm_cycles);
        return $clog2(confirm_cycles + 1);
    endfunction

    // Index of the lowest set bit; 0 when the mask is empty.
    // Scanning from the top down lets the lowest set bit overwrite last.
    function automatic logic [DL_MAX_IDX_W-1:0] lowest_set_idx(
        input logic [DL_MAX_MON-1:0] mask
    );
        lowest_set_idx = '0;
        for (int i = DL_MAX_MON - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest_set_idx = DL_MAX_IDX_W'(i);
            end
        end
    endfunction

endpackage

// File: rtl/dl_lowest_set_encoder.sv
// Priority encoder: index of the lowest set bit of i_mask (0 if none).
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   i_mask  in   NUM_MON  bit vector to encode
//   o_idx   out  IDX_W    lowest set bit index
module dl_lowest_set_encoder
    import deadlock_collect_pkg::*;
#(
    parameter int NUM_MON = 13,
    parameter int IDX_W   = 4
) (
    input  logic [NUM_MON-1:0] i_mask,
    output logic [IDX_W-1:0]   o_idx
);

    logic [DL_MAX_MON-1:0]   w_mask_ext;
    logic [DL_MAX_IDX_W-1:0] w_idx_full;
    logic [DL_MAX_IDX_W-1:0] w_unused_idx;

    assign w_mask_ext   = DL_MAX_MON'(i_mask);
    assign w_idx_full   = lowest_set_idx(w_mask_ext);
    // Upper index bits are always zero because the mask is zero-extended.
    assign w_unused_idx = w_idx_full;
    assign o_idx        = w_idx_full[IDX_W-1:0];

endmodule

// File: rtl/deadlock_report_collector.sv
// Confirms a deadlock after CONFIRM_CYCLES consecutive blocked cycles and issues one report.
// Latency: report_valid rises the cycle after the CONFIRM_CYCLES-th consecutive blocked edge.
// Backpressure: report held stable until report_ready; report_valid is registered (no ready->valid path).
//
// Ports:
//   clock, reset (sync, active-high)
//   mon_block      in   NUM_MON  per-monitor block flags
//   dut_done       in   1        suppresses detection when high
//   report_ready   in   1        reporter accepts the record
//   report_valid   out  1        record available
//   report_idx     out  IDX_W    lowest blocked monitor at confirmation
//   report_mask    out  NUM_MON  mon_block snapshot at confirmation
//   report_cycle   out  CYC_W    cycle_count at confirmation
//   deadlock_flag  out  1        sticky confirmed flag
//   cycle_count    out  CYC_W    saturating free-running counter
module deadlock_report_collector
    import deadlock_collect_pkg::*;
#(
    parameter int NUM_MON        = 13,
    parameter int IDX_W          = 4,
    parameter int CONFIRM_CYCLES = 16,
    parameter int CYC_W          = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] mon_block,
    input  logic               dut_done,
    input  logic               report_ready,
    output logic               report_valid,
    output logic [IDX_W-1:0]   report_idx,
    output logic [NUM_MON-1:0] report_mask,
    output logic [CYC_W-1:0]   report_cycle,
    output logic               deadlock_flag,
    output logic [CYC_W-1:0]   cycle_count
);

    localparam int HOLD_W = hold_cnt_w(CONFIRM_CYCLES);

    dl_state_t          r_state;
    dl_state_t          w_state_nxt;
    logic [HOLD_W-1:0]  r_hold;
    logic [HOLD_W-1:0]  w_hold_nxt;
    logic [HOLD_W-1:0]  w_hold_inc;
    logic               w_blocked;
    logic               w_capture;
    logic               w_accept;
    logic [IDX_W-1:0]   w_low_idx;

    logic               r_valid;
    logic               r_flag;
    logic [IDX_W-1:0]   r_idx;
    logic [NUM_MON-1:0] r_mask;
    logic [CYC_W-1:0]   r_rcyc;
    logic [CYC_W-1:0]   r_cyc;

    dl_lowest_set_encoder #(
        .NUM_MON (NUM_MON),
        .IDX_W   (IDX_W)
    ) u_enc (
        .i_mask (mon_block),
        .o_idx  (w_low_idx)
    );

    assign w_blocked  = |mon_block;
    assign w_hold_inc = r_hold + HOLD_W'(1);

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // FSM next-state and capture/accept strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                w_hold_nxt = '0;
                if (w_blocked && !dut_done) begin
                    w_hold_nxt = HOLD_W'(1);
                    if (CONFIRM_CYCLES == 1) begin
                        w_state_nxt = REPORT;
                        w_capture   = 1'b1;
                    end else begin
                        w_state_nxt = WATCH;
                    end
                end
            end
            WATCH: begin
                // Only a fully clear mask (or DUT completion) restarts the
                // window; a change in which monitors are blocked does not.
                if (!w_blocked || dut_done) begin
                    w_hold_nxt  = '0;
                    w_state_nxt = IDLE;
                end else if (w_hold_inc == HOLD_W'(CONFIRM_CYCLES)) begin
                    w_state_nxt = REPORT;
                    w_capture   = 1'b1;
                end else begin
                    w_hold_nxt = w_hold_inc;
                end
            end
            REPORT: begin
                // r_valid is always high in REPORT, so ready alone completes it.
                if (report_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = LATCHED;
                end
            end
            LATCHED: begin
                w_state_nxt = LATCHED;
            end
            default: begin
                w_state_nxt = IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // Cycle counter and report payload.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cyc   <= '0;
            r_valid <= 1'b0;
            r_flag  <= 1'b0;
            r_idx   <= '0;
            r_mask  <= '0;
            r_rcyc  <= '0;
        end else begin
            if (r_cyc != {CYC_W{1'b1}}) begin
                r_cyc <= r_cyc + CYC_W'(1);
            end
            if (w_capture) begin
                r_mask  <= mon_block;
                r_idx   <= w_low_idx;
                r_rcyc  <= r_cyc;
                r_valid <= 1'b1;
                r_flag  <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign report_valid  = r_valid;
    assign report_idx    = r_idx;
    assign report_mask   = r_mask;
    assign report_cycle  = r_rcyc;
    assign deadlock_flag = r_flag;
    assign cycle_count   = r_cyc;

endmodule

// File: tb/tb_deadlock_report_collector.sv
// Directed bench for deadlock_report_collector (CONFIRM_CYCLES=16 and =1 instances).
// Latency: n/a.
// Backpressure: exercised via report_ready held low while mon_block toggles.
module tb_deadlock_report_collector;

    logic        clock;
    logic        reset;
    logic [3:0]  mon_block;
    logic        dut_done;
    logic        report_ready;
    logic        report_valid;
    logic [1:0]  report_idx;
    logic [3:0]  report_mask;
    logic [31:0] report_cycle;
    logic        deadlock_flag;
    logic [31:0] cycle_count;

    logic [3:0]  mon_block1;
    logic        dut_done1;
    logic        report_ready1;
    logic        report_valid1;
    logic [1:0]  report_idx1;
    logic [3:0]  report_mask1;
    logic [31:0] report_cycle1;
    logic        deadlock_flag1;
    logic [31:0] cycle_count1;

    int n_checks = 0;
    int n_fail   = 0;

    deadlock_report_collector #(
        .NUM_MON(4), .IDX_W(2), .CONFIRM_CYCLES(16), .CYC_W(32)
    ) u_dut (
        .clock         (clock),
        .reset         (reset),
        .mon_block     (mon_block),
        .dut_done      (dut_done),
        .report_ready  (report_ready),
        .report_valid  (report_valid),
        .report_idx    (report_idx),
        .report_mask   (report_mask),
        .report_cycle  (report_cycle),
        .deadlock_flag (deadlock_flag),
        .cycle_count   (cycle_count)
    );

    deadlock_report_collector #(
        .NUM_MON(4), .IDX_W(2), .CONFIRM_CYCLES(1), .CYC_W(32)
    ) u_dut_c1 (
        .clock         (clock),
        .reset         (reset),
        .mon_block     (mon_block1),
        .dut_done      (dut_done1),
        .report_ready  (report_ready1),
        .report_valid  (report_valid1),
        .report_idx    (report_idx1),
        .report_mask   (report_mask1),
        .report_cycle  (report_cycle1),
        .deadlock_flag (deadlock_flag1),
        .cycle_count   (cycle_count1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; return 1 time unit after the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        tick(n);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0]  pat;
        mon_block     = 4'b0000;
        dut_done      = 1'b0;
        report_ready  = 1'b0;
        mon_block1    = 4'b0000;
        dut_done1     = 1'b0;
        report_ready1 = 1'b0;
        reset         = 1'b1;

        // Reset state.
        tick(2);
        check_eq("rst_valid", report_valid, 0);
        check_eq("rst_flag", deadlock_flag, 0);
        check_eq("rst_idx", report_idx, 0);
        check_eq("rst_mask", report_mask, 0);
        check_eq("rst_rcyc", report_cycle, 0);
        check_eq("rst_cyc", cycle_count, 0);
        reset = 1'b0;

        // Idle run.
        tick(100);
        check_eq("idle_valid", report_valid, 0);
        check_eq("idle_flag", deadlock_flag, 0);
        check_eq("idle_cyc", cycle_count, 100);

        // Glitch: 15 blocked cycles then clear.
        mon_block = 4'b0100;
        tick(15);
        mon_block = 4'b0000;
        tick(1);
        check_eq("glitch_valid", report_valid, 0);
        check_eq("glitch_flag", deadlock_flag, 0);
        tick(84);
        check_eq("glitch_cyc200", cycle_count, 200);

        // Sustained block from cycle 200.
        mon_block = 4'b0100;
        tick(15);
        check_eq("conf_early_valid", report_valid, 0);
        tick(1);
        check_eq("conf_valid", report_valid, 1);
        check_eq("conf_idx", report_idx, 2);
        check_eq("conf_mask", report_mask, 4'b0100);
        check_eq("conf_rcyc", report_cycle, 215);
        check_eq("conf_flag", deadlock_flag, 1);

        // Backpressure with toggling inputs.
        for (int i = 0; i < 10; i++) begin
            pat = 4'(i + 5);
            mon_block = pat;
            dut_done  = i[0];
            tick(1);
            check_eq("bp_valid", report_valid, 1);
            check_eq("bp_mask", report_mask, 4'b0100);
            check_eq("bp_idx", report_idx, 2);
            check_eq("bp_rcyc", report_cycle, 215);
        end
        dut_done     = 1'b0;
        report_ready = 1'b1;
        tick(1);
        report_ready = 1'b0;
        check_eq("acc_valid", report_valid, 0);
        check_eq("acc_flag", deadlock_flag, 1);
        mon_block = 4'b1111;
        tick(20);
        check_eq("latched_valid", report_valid, 0);
        check_eq("latched_flag", deadlock_flag, 1);
        check_eq("latched_mask", report_mask, 4'b0100);
        check_eq("latched_idx", report_idx, 2);

        // Moving mask: bit set changes mid-window without restarting.
        mon_block = 4'b0000;
        do_reset(2);
        check_eq("r2_flag", deadlock_flag, 0);
        mon_block = 4'b0100;
        tick(8);
        mon_block = 4'b0110;
        tick(7);
        check_eq("mv_early_valid", report_valid, 0);
        tick(1);
        check_eq("mv_valid", report_valid, 1);
        check_eq("mv_idx", report_idx, 1);
        check_eq("mv_mask", report_mask, 4'b0110);
        check_eq("mv_rcyc", report_cycle, 15);
        report_ready = 1'b1;
        tick(1);
        report_ready = 1'b0;
        check_eq("mv_acc_valid", report_valid, 0);

        // dut_done suppression; afterwards a full fresh window is needed.
        mon_block = 4'b0000;
        do_reset(2);
        mon_block = 4'b0001;
        tick(10);
        dut_done = 1'b1;
        tick(20);
        check_eq("done_valid", report_valid, 0);
        check_eq("done_flag", deadlock_flag, 0);
        dut_done = 1'b0;
        tick(15);
        check_eq("done_restart_valid", report_valid, 0);
        tick(1);
        check_eq("done_rep_valid", report_valid, 1);
        check_eq("done_rep_idx", report_idx, 0);
        check_eq("done_rep_mask", report_mask, 4'b0001);
        check_eq("done_rep_rcyc", report_cycle, 45);

        // Reset while in REPORT.
        reset = 1'b1;
        tick(1);
        check_eq("midrst_valid", report_valid, 0);
        check_eq("midrst_flag", deadlock_flag, 0);
        check_eq("midrst_idx", report_idx, 0);
        check_eq("midrst_mask", report_mask, 0);
        check_eq("midrst_rcyc", report_cycle, 0);
        check_eq("midrst_cyc", cycle_count, 0);
        reset     = 1'b0;
        mon_block = 4'b1000;
        tick(16);
        check_eq("re_valid", report_valid, 1);
        check_eq("re_idx", report_idx, 3);
        check_eq("re_mask", report_mask, 4'b1000);
        check_eq("re_rcyc", report_cycle, 15);
        check_eq("re_flag", deadlock_flag, 1);

        // CONFIRM_CYCLES=1: one blocked cycle reports on the next.
        check_eq("c1_pre_valid", report_valid1, 0);
        mon_block1 = 4'b0010;
        tick(1);
        mon_block1 = 4'b0000;
        check_eq("c1_valid", report_valid1, 1);
        check_eq("c1_idx", report_idx1, 1);
        check_eq("c1_mask", report_mask1, 4'b0010);
        check_eq("c1_rcyc", report_cycle1, 16);
        check_eq("c1_flag", deadlock_flag1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
